// File: rtl/apb_arb_pkg.sv
// ----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and sizing helpers for the APB master arbiter.
//   arb_state_t  : downstream transfer phase (IDLE / SETUP / ACCESS)
//   ptr_width()  : bits needed to hold a requester index
//   cnt_width()  : bits needed for the ACCESS wait counter, $clog2(TIMEOUT+1)
// ----------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A disabled timeout (0) still gets a 1-bit counter so widths stay legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req searching
// upward from ptr+1, wrapping at N.
//   req : N    request vector
//   ptr : PW   index of the last winner
//   gnt : N    one-hot winner, 0 when req is 0
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    localparam int SW = PW + 1;

    logic [SW-1:0] sh;
    logic [N-1:0]  rreq;
    logic [N-1:0]  rgnt;

    // Rotate so the highest-priority requester sits at bit 0, take the lowest
    // set bit, then rotate the grant back into place.
    always_comb begin
        sh   = (ptr == PW'(N - 1)) ? '0 : ({1'b0, ptr} + SW'(1));
        rreq = N'({req, req} >> sh);
        rgnt = rreq & (~rreq + N'(1));
        gnt  = N'(({rgnt, rgnt} << sh) >> N);
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one downstream APB port between NB_REQ requesters. Round-robin grant,
// a single transfer in flight, registered SETUP/ACCESS sequencing and a
// per-transfer pready timeout that answers the owner with PSLVERR.
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   s_psel_i/s_penable_i    per-requester select / enable
//   s_pwrite_i              per-requester direction
//   s_paddr_i/s_pwdata_i    flattened per-requester address / write data
//   s_prdata_o              flattened read data, only the owner's slice driven
//   s_pready_o/s_pslverr_o  one-hot completion / error to the owner
//   m_*                     downstream APB master port (psel/penable registered)
//   grant_o                 one-hot owner, 0 while IDLE
//   timeout_o               one-cycle pulse when a transfer is aborted
//
// state  | meaning
// IDLE   | no transfer; arbitrate and capture the winner's request
// SETUP  | m_psel=1, m_penable=0 for one cycle
// ACCESS | m_penable=1, wait for m_pready_i or the timeout
// ----------------------------------------------------------------------------
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NB_REQ         = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_REQ-1:0]                s_psel_i,
    input  logic [NB_REQ-1:0]                s_penable_i,
    input  logic [NB_REQ-1:0]                s_pwrite_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] s_paddr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0] s_pwdata_i,
    output logic [NB_REQ*APB_DATA_WIDTH-1:0] s_prdata_o,
    output logic [NB_REQ-1:0]                s_pready_o,
    output logic [NB_REQ-1:0]                s_pslverr_o,
    output logic                             m_psel_o,
    output logic                             m_penable_o,
    output logic                             m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]        m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]        m_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]        m_prdata_i,
    input  logic                             m_pready_i,
    input  logic                             m_pslverr_i,
    output logic [NB_REQ-1:0]                grant_o,
    output logic                             timeout_o
);

    localparam int AW    = APB_ADDR_WIDTH;
    localparam int DW    = APB_DATA_WIDTH;
    localparam int PW    = ptr_width(NB_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_t        state;
    logic [NB_REQ-1:0] arb_gnt;
    logic [NB_REQ-1:0] grant_q;
    logic [PW-1:0]     ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [PW-1:0]     win_idx;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_data;
    logic              win_write;

    logic              timeout_hit;
    logic              resp_done;

    rr_arbiter #(
        .N  (NB_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req (s_psel_i),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        win_idx   = '0;
        win_addr  = '0;
        win_data  = '0;
        win_write = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (arb_gnt[k]) begin
                win_idx   = PW'(k);
                win_addr  = s_paddr_i[k*AW +: AW];
                win_data  = s_pwdata_i[k*DW +: DW];
                win_write = s_pwrite_i[k];
            end
        end
    end

    // The timeout fires on the ACCESS cycle where the counter sits at
    // TIMEOUT-1; a pready arriving on that same cycle takes precedence.
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_ACCESS) && !m_pready_i &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));
    assign resp_done   = (state == ST_ACCESS) && (m_pready_i || timeout_hit);
    assign timeout_o   = timeout_hit;
    assign grant_o     = grant_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= PW'(NB_REQ - 1);
            cnt_q       <= '0;
            m_psel_o    <= 1'b0;
            m_penable_o <= 1'b0;
            m_pwrite_o  <= 1'b0;
            m_paddr_o   <= '0;
            m_pwdata_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|s_psel_i) begin
                        grant_q    <= arb_gnt;
                        ptr_q      <= win_idx;
                        m_paddr_o  <= win_addr;
                        m_pwdata_o <= win_data;
                        m_pwrite_o <= win_write;
                        m_psel_o   <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable_o <= 1'b1;
                    cnt_q       <= '0;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (resp_done) begin
                        m_psel_o    <= 1'b0;
                        m_penable_o <= 1'b0;
                        grant_q     <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A waiting requester sits in its own access phase (psel and penable high).
    // If the owner has let go of either, it abandoned the transfer: the
    // downstream side still completes but nothing is reflected back.
    always_comb begin
        s_pready_o  = '0;
        s_pslverr_o = '0;
        s_prdata_o  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (resp_done && grant_q[k] && s_psel_i[k] && s_penable_i[k]) begin
                s_pready_o[k]  = 1'b1;
                s_pslverr_o[k] = timeout_hit | m_pslverr_i;
                if (!timeout_hit) begin
                    s_prdata_o[k*DW +: DW] = m_prdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Randomized bench for apb_master_arbiter (NB_REQ=4, TIMEOUT=8). Expected
// winners come from a plain round-robin search over the request mask starting
// after the last winner; responses are predicted from the slave behaviour the
// bench itself drives.
// ----------------------------------------------------------------------------
module tb_apb_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    s_psel_i;
    logic [N-1:0]    s_penable_i;
    logic [N-1:0]    s_pwrite_i;
    logic [N*AW-1:0] s_paddr_i;
    logic [N*DW-1:0] s_pwdata_i;
    logic [N*DW-1:0] s_prdata_o;
    logic [N-1:0]    s_pready_o;
    logic [N-1:0]    s_pslverr_o;
    logic            m_psel_o;
    logic            m_penable_o;
    logic            m_pwrite_o;
    logic [AW-1:0]   m_paddr_o;
    logic [DW-1:0]   m_pwdata_o;
    logic [DW-1:0]   m_prdata_i;
    logic            m_pready_i;
    logic            m_pslverr_i;
    logic [N-1:0]    grant_o;
    logic            timeout_o;

    int checks   = 0;
    int failures = 0;
    int last_win = N - 1;

    always #5 clk_i = ~clk_i;

    apb_master_arbiter #(
        .NB_REQ         (N),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_psel_i    (s_psel_i),
        .s_penable_i (s_penable_i),
        .s_pwrite_i  (s_pwrite_i),
        .s_paddr_i   (s_paddr_i),
        .s_pwdata_i  (s_pwdata_i),
        .s_prdata_o  (s_prdata_o),
        .s_pready_o  (s_pready_o),
        .s_pslverr_o (s_pslverr_o),
        .m_psel_o    (m_psel_o),
        .m_penable_o (m_penable_o),
        .m_pwrite_o  (m_pwrite_o),
        .m_paddr_o   (m_paddr_o),
        .m_pwdata_o  (m_pwdata_o),
        .m_prdata_i  (m_prdata_i),
        .m_pready_i  (m_pready_i),
        .m_pslverr_i (m_pslverr_i),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    // Reference round robin: first requester after the last winner, wrapping.
    function automatic int model_winner(input logic [N-1:0] req);
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (last_win + i) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic drive_idle();
        s_psel_i    = '0;
        s_penable_i = '0;
        s_pwrite_i  = '0;
        s_paddr_i   = '0;
        s_pwdata_i  = '0;
        m_prdata_i  = '0;
        m_pready_i  = 1'b0;
        m_pslverr_i = 1'b0;
    endtask

    task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_psel_i[k]          = 1'b1;
        s_penable_i[k]       = 1'b0;
        s_pwrite_i[k]        = wr;
        s_paddr_i[k*AW +: AW] = a;
        s_pwdata_i[k*DW +: DW] = d;
    endtask

    // Advance to the downstream SETUP cycle; requesters then enter their
    // own access phase and hold penable high while waiting.
    task automatic wait_setup(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #1;
            if (m_psel_o && !m_penable_o) begin
                ok = 1'b1;
                break;
            end
        end
        s_penable_i = s_psel_i;
    endtask

    // Behavioural slave: stalls `lat` ACCESS cycles (forever if `never`),
    // then answers. Returns what the owner side saw on the completion cycle.
    // Leaves the caller at the negedge of the cycle after completion.
    task automatic serve(input int lat, input bit err, input logic [DW-1:0] rdata, input bit never,
                         output bit found, output int acc, output logic [N-1:0] rp,
                         output logic [N-1:0] re, output logic [N*DW-1:0] rd, output logic to);
        found = 1'b0;
        acc   = 0;
        rp    = '0;
        re    = '0;
        rd    = '0;
        to    = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk_i);
            if (!m_penable_o) continue;
            m_pready_i  = !never && (acc >= lat);
            m_pslverr_i = m_pready_i ? err : 1'($urandom);
            m_prdata_i  = m_pready_i ? rdata : ($urandom | 32'h1);
            acc++;
            #1;
            if (s_pready_o != '0 || timeout_o) begin
                rp    = s_pready_o;
                re    = s_pslverr_o;
                rd    = s_prdata_o;
                to    = timeout_o;
                found = 1'b1;
                break;
            end
        end
        @(negedge clk_i);
        m_pready_i  = 1'b0;
        m_pslverr_i = 1'b0;
        m_prdata_i  = '0;
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if ({m_psel_o, m_penable_o, grant_o, timeout_o} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {m_psel_o, m_penable_o, grant_o, timeout_o});
        end
        checks++;
        if ({s_pready_o, s_pslverr_o, s_prdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_resp got=%h exp=0", {s_pready_o, s_pslverr_o, s_prdata_o});
        end
        checks++;
        if ({m_pwrite_o, m_paddr_o, m_pwdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_capture got=%h exp=0", {m_pwrite_o, m_paddr_o, m_pwdata_o});
        end
        rst_i    = 1'b0;
        last_win = N - 1;
    endtask

    task automatic test_single_write();
        bit ok, found;
        int acc, w;
        logic [N-1:0] rp, re;
        logic [N*DW-1:0] rd;
        logic to;
        @(negedge clk_i);
        set_req(1, 1'b1, 32'h1A00_0010, 32'hDEAD_BEEF);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        checks++;
        if (!ok || grant_o !== onehot(w)) begin
            failures++;
            $display("FAIL single_grant ok=%0d got=%b exp=%b", ok, grant_o, onehot(w));
        end
        checks++;
        if ({m_pwrite_o, m_paddr_o, m_pwdata_o} !== {1'b1, 32'h1A00_0010, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_capture got=%b/%h/%h", m_pwrite_o, m_paddr_o, m_pwdata_o);
        end
        last_win = w;
        serve(0, 1'b0, 32'h0, 1'b0, found, acc, rp, re, rd, to);
        checks++;
        if (!found || acc != 1 || rp !== onehot(w) || re !== '0 || to !== 1'b0) begin
            failures++;
            $display("FAIL single_resp found=%0d acc=%0d pready=%b slverr=%b to=%b exp acc=1 pready=%b",
                     found, acc, rp, re, to, onehot(w));
        end
        checks++;
        if (m_psel_o !== 1'b0 || m_penable_o !== 1'b0 || grant_o !== '0) begin
            failures++;
            $display("FAIL single_drop psel=%b pen=%b grant=%b exp 0", m_psel_o, m_penable_o, grant_o);
        end
        drive_idle();
    endtask

    task automatic test_all_held();
        bit ok, found;
        int acc, w;
        logic [N-1:0] rp, re, prev;
        logic [N*DW-1:0] rd;
        logic to;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i    = 1'b0;
        last_win = N - 1;
        for (int k = 0; k < N; k++) set_req(k, 1'($urandom), $urandom, $urandom);
        prev = '0;
        for (int t = 0; t < N + 1; t++) begin
            w = model_winner(s_psel_i);
            wait_setup(ok);
            checks++;
            if (!ok || grant_o !== onehot(w) || grant_o === prev) begin
                failures++;
                $display("FAIL all_held_grant t=%0d got=%b exp=%b prev=%b", t, grant_o, onehot(w), prev);
            end
            prev     = grant_o;
            last_win = w;
            serve($urandom_range(0, 2), 1'b0, $urandom, 1'b0, found, acc, rp, re, rd, to);
            checks++;
            if (!found || rp !== onehot(w)) begin
                failures++;
                $display("FAIL all_held_resp t=%0d got=%b exp=%b", t, rp, onehot(w));
            end
        end
        drive_idle();
    endtask

    task automatic test_read_stall();
        bit ok, found;
        int acc, w;
        logic [N-1:0] rp, re;
        logic [N*DW-1:0] rd, exp_rd;
        logic to;
        @(negedge clk_i);
        set_req(2, 1'b0, $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        checks++;
        if (!ok || grant_o !== onehot(w) || m_pwrite_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_grant got=%b exp=%b pwrite=%b", grant_o, onehot(w), m_pwrite_o);
        end
        last_win = w;
        serve(5, 1'b0, 32'h1234_5678, 1'b0, found, acc, rp, re, rd, to);
        exp_rd = '0;
        exp_rd[2*DW +: DW] = 32'h1234_5678;
        checks++;
        if (!found || acc != 6 || rp !== 4'b0100 || re !== '0) begin
            failures++;
            $display("FAIL stall_resp acc=%0d exp=6 pready=%b slverr=%b", acc, rp, re);
        end
        checks++;
        if (rd !== exp_rd) begin
            failures++;
            $display("FAIL stall_prdata got=%h exp=%h", rd, exp_rd);
        end
        drive_idle();
    endtask

    task automatic test_timeout();
        bit ok, found;
        int acc, w, k;
        logic [N-1:0] rp, re;
        logic [N*DW-1:0] rd;
        logic to;
        k = $urandom_range(0, N - 1);
        @(negedge clk_i);
        set_req(k, 1'($urandom), $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        last_win = w;
        serve(0, 1'b0, 32'h0, 1'b1, found, acc, rp, re, rd, to);
        checks++;
        if (!found || acc != TO || rp !== onehot(w) || re !== onehot(w) || to !== 1'b1) begin
            failures++;
            $display("FAIL timeout_resp acc=%0d exp=%0d pready=%b slverr=%b to=%b exp=%b",
                     acc, TO, rp, re, to, onehot(w));
        end
        checks++;
        if (rd !== '0) begin
            failures++;
            $display("FAIL timeout_prdata got=%h exp=0", rd);
        end
        checks++;
        if (timeout_o !== 1'b0 || m_psel_o !== 1'b0 || grant_o !== '0) begin
            failures++;
            $display("FAIL timeout_after to=%b psel=%b grant=%b exp 0", timeout_o, m_psel_o, grant_o);
        end
        drive_idle();
        k = (k + 1) % N;
        set_req(k, 1'b1, $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        last_win = w;
        serve(1, 1'b0, 32'h0, 1'b0, found, acc, rp, re, rd, to);
        checks++;
        if (!found || rp !== onehot(w) || re !== '0 || to !== 1'b0) begin
            failures++;
            $display("FAIL timeout_next pready=%b slverr=%b to=%b exp pready=%b", rp, re, to, onehot(w));
        end
        drive_idle();
    endtask

    task automatic test_slverr();
        bit ok, found;
        int acc, w, k;
        logic [N-1:0] rp, re;
        logic [N*DW-1:0] rd, exp_rd;
        logic [DW-1:0] data;
        logic to;
        k    = $urandom_range(0, N - 1);
        data = $urandom;
        @(negedge clk_i);
        set_req(k, 1'b0, $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        last_win = w;
        serve($urandom_range(0, 3), 1'b1, data, 1'b0, found, acc, rp, re, rd, to);
        exp_rd = '0;
        exp_rd[w*DW +: DW] = data;
        checks++;
        if (!found || rp !== onehot(w) || re !== onehot(w) || to !== 1'b0 || rd !== exp_rd) begin
            failures++;
            $display("FAIL slverr_resp pready=%b slverr=%b to=%b prdata=%h exp=%b/%h",
                     rp, re, to, rd, onehot(w), exp_rd);
        end
        drive_idle();
    endtask

    task automatic test_random();
        bit ok, found, err;
        int acc, w, lat;
        logic [N-1:0] rp, re, mask, wr;
        logic [N*DW-1:0] rd, exp_rd;
        logic [AW-1:0] addr [N];
        logic [DW-1:0] wdat [N];
        logic [DW-1:0] data;
        logic to;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk_i);
            mask = 4'($urandom_range(1, 15));
            wr   = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                addr[k] = $urandom;
                wdat[k] = $urandom;
                if (mask[k]) set_req(k, wr[k], addr[k], wdat[k]);
            end
            w = model_winner(mask);
            wait_setup(ok);
            checks++;
            if (!ok || grant_o !== onehot(w) || m_paddr_o !== addr[w] ||
                m_pwdata_o !== wdat[w] || m_pwrite_o !== wr[w]) begin
                failures++;
                $display("FAIL rand_grant t=%0d mask=%b got=%b exp=%b addr=%h/%h", t, mask, grant_o,
                         onehot(w), m_paddr_o, addr[w]);
            end
            last_win = w;
            lat  = $urandom_range(0, 3);
            err  = 1'($urandom);
            data = $urandom;
            serve(lat, err, data, 1'b0, found, acc, rp, re, rd, to);
            exp_rd = '0;
            exp_rd[w*DW +: DW] = data;
            checks++;
            if (!found || acc != lat + 1 || rp !== onehot(w) || re !== (err ? onehot(w) : 4'b0) ||
                rd !== exp_rd || to !== 1'b0) begin
                failures++;
                $display("FAIL rand_resp t=%0d acc=%0d/%0d pready=%b slverr=%b to=%b exp=%b err=%0d",
                         t, acc, lat + 1, rp, re, to, onehot(w), err);
            end
            drive_idle();
        end
    endtask

    task automatic test_owner_drop();
        bit ok, found;
        int acc, w;
        logic [N-1:0] rp, re;
        logic [N*DW-1:0] rd;
        logic to;
        @(negedge clk_i);
        set_req(3, 1'b0, $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        last_win = w;
        @(negedge clk_i);
        s_psel_i    = '0;
        s_penable_i = '0;
        m_pready_i  = 1'b1;
        m_prdata_i  = $urandom | 32'h1;
        #1;
        checks++;
        if (m_penable_o !== 1'b1 || s_pready_o !== '0 || s_prdata_o !== '0) begin
            failures++;
            $display("FAIL drop_discard pen=%b pready=%b prdata=%h exp pen=1 rest 0",
                     m_penable_o, s_pready_o, s_prdata_o);
        end
        @(negedge clk_i);
        m_pready_i = 1'b0;
        m_prdata_i = '0;
        #1;
        checks++;
        if (m_psel_o !== 1'b0 || grant_o !== '0) begin
            failures++;
            $display("FAIL drop_idle psel=%b grant=%b exp 0", m_psel_o, grant_o);
        end
        set_req(0, 1'b1, $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        last_win = w;
        serve(0, 1'b0, 32'h0, 1'b0, found, acc, rp, re, rd, to);
        checks++;
        if (!found || rp !== onehot(w)) begin
            failures++;
            $display("FAIL drop_recover pready=%b exp=%b", rp, onehot(w));
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        int acc, w;
        logic [N-1:0] rp, re;
        logic [N*DW-1:0] rd;
        logic to;
        @(negedge clk_i);
        set_req(2, 1'b1, $urandom, $urandom);
        wait_setup(ok);
        @(negedge clk_i);
        checks++;
        if (m_penable_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_access pen=%b exp=1", m_penable_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (m_psel_o !== 1'b0 || m_penable_o !== 1'b0 || grant_o !== '0 || s_pready_o !== '0) begin
            failures++;
            $display("FAIL rstmid_clear psel=%b pen=%b grant=%b pready=%b exp 0",
                     m_psel_o, m_penable_o, grant_o, s_pready_o);
        end
        @(negedge clk_i);
        rst_i    = 1'b0;
        last_win = N - 1;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, $urandom, $urandom);
        w = model_winner(s_psel_i);
        wait_setup(ok);
        checks++;
        if (!ok || grant_o !== onehot(w) || grant_o !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_first got=%b exp=%b", grant_o, onehot(w));
        end
        last_win = w;
        serve(0, 1'b0, 32'h0, 1'b0, found, acc, rp, re, rd, to);
        drive_idle();
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_all_held();
        test_read_stall();
        test_timeout();
        test_slverr();
        test_random();
        test_owner_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
